wb_spi_slave: RTL and testbench



---
 rtl/wb_spi_slave.sv | 168 ++++++++++++++++
 tb/tb_wb_spi_slave.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_spi_slave.sv
// SPI mode-0 slave with a Wishbone register port: a CPU-supplied byte shifts out on MISO
// while the external master's byte is captured into a holding register for the CPU to read.
module wb_spi_slave #(
    parameter logic [7:0] idle_byte = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    input  logic        spi_ss_n,
    output logic        spi_miso,
    output logic        intr
);

    logic       sck_p0, sck_p1, sck_p2;
    logic       mosi_p0, mosi_p1;
    logic       ss_p0, ss_p1, ss_p2;
    logic       settled, armed, in_frame;
    logic [2:0] bit_cnt;
    logic [7:0] rx_sr, rx_hold, tx_sr, tx_hold;
    logic       rx_avail, tx_valid, overrun;
    logic [2:0] ctrl;

    logic       sck_rise, sck_fall, ss_fall, ss_rise;
    logic       access, rd, wr;
    logic [1:0] reg_sel;
    logic       rx_clr, tx_wr, ovr_clr, ctrl_wr;
    logic [7:0] rx_byte;
    logic       byte_done, tx_reload;
    logic [31:0] rd_data;
    logic       unused_bits;

    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8]};

    function automatic logic [7:0] reload_byte(input logic valid, input logic [7:0] hold);
        return valid ? hold : idle_byte;
    endfunction

    // Edge detection on the synchronised pins; SCK edges only count inside an armed frame.
    assign sck_rise  = in_frame & ~ss_p1 & sck_p1 & ~sck_p2;
    assign sck_fall  = in_frame & ~ss_p1 & ~sck_p1 & sck_p2;
    assign ss_fall   = armed & ss_p2 & ~ss_p1;
    assign ss_rise   = ~ss_p2 & ss_p1;

    assign access    = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign rd        = access & ~wb_we_i;
    assign wr        = access & wb_we_i;
    assign reg_sel   = wb_adr_i[3:2];
    assign rx_clr    = rd && (reg_sel == 2'd0);
    assign tx_wr     = wr && (reg_sel == 2'd1);
    assign ovr_clr   = wr && (reg_sel == 2'd2) && wb_dat_i[2];
    assign ctrl_wr   = wr && (reg_sel == 2'd3);

    assign rx_byte   = {rx_sr[6:0], mosi_p1};
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign tx_reload = ss_fall || (sck_fall && (bit_cnt == 3'd0));

    assign spi_miso  = ss_p1 ? 1'b1 : tx_sr[7];

    always_comb begin
        rd_data = 32'd0;
        case (reg_sel)
            2'd0: rd_data = {24'd0, rx_hold};
            2'd1: rd_data = {24'd0, tx_hold};
            2'd2: rd_data = {28'd0, ~ss_p1, overrun, ~tx_valid, rx_avail};
            2'd3: rd_data = {29'd0, ctrl};
            default: rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_p0   <= 1'b0;
            sck_p1   <= 1'b0;
            sck_p2   <= 1'b0;
            mosi_p0  <= 1'b0;
            mosi_p1  <= 1'b0;
            ss_p0    <= 1'b1;
            ss_p1    <= 1'b1;
            ss_p2    <= 1'b1;
            settled  <= 1'b0;
            armed    <= 1'b0;
            in_frame <= 1'b0;
            bit_cnt  <= 3'd0;
            rx_sr    <= 8'd0;
            rx_hold  <= 8'd0;
            tx_sr    <= idle_byte;
            tx_hold  <= 8'd0;
            rx_avail <= 1'b0;
            tx_valid <= 1'b0;
            overrun  <= 1'b0;
            ctrl     <= 3'd0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'd0;
            intr     <= 1'b0;
        end else begin
            sck_p0  <= spi_sck;
            sck_p1  <= sck_p0;
            sck_p2  <= sck_p1;
            mosi_p0 <= spi_mosi;
            mosi_p1 <= mosi_p0;
            ss_p0   <= spi_ss_n;
            ss_p1   <= ss_p0;
            ss_p2   <= ss_p1;

            // A frame already open across reset must not resume: arm only once ss_n is seen high.
            settled <= 1'b1;
            if (settled && ss_p0)
                armed <= 1'b1;

            if (ss_fall)
                in_frame <= 1'b1;
            else if (ss_rise)
                in_frame <= 1'b0;

            if (ss_fall || ss_rise)
                bit_cnt <= 3'd0;
            else if (sck_rise)
                bit_cnt <= bit_cnt + 3'd1;

            if (sck_rise)
                rx_sr <= rx_byte;

            if (tx_reload)
                tx_sr <= reload_byte(tx_valid, tx_hold);
            else if (sck_fall)
                tx_sr <= {tx_sr[6:0], 1'b0};

            if (tx_wr) begin
                tx_hold  <= wb_dat_i[7:0];
                tx_valid <= 1'b1;
            end else if (tx_reload) begin
                tx_valid <= 1'b0;
            end

            // A read draining the holder in the completion cycle frees it for the new byte.
            if (byte_done && (!rx_avail || rx_clr)) begin
                rx_hold  <= rx_byte;
                rx_avail <= 1'b1;
            end else if (rx_clr) begin
                rx_avail <= 1'b0;
            end

            if (byte_done && rx_avail && !rx_clr)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;

            if (ctrl_wr)
                ctrl <= wb_dat_i[2:0];

            wb_ack_o <= access;
            if (access)
                wb_dat_o <= rd_data;

            intr <= (ctrl[0] & rx_avail) | (ctrl[1] & ~tx_valid) | (ctrl[2] & overrun);
        end
    end

endmodule

// File: tb/tb_wb_spi_slave.sv
// Directed bench for wb_spi_slave: drives a mode-0 SPI master at SCK = clk/8 and
// a Wishbone master, checking every observation against hand-computed values.
`timescale 1ns/1ps
module tb_wb_spi_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] wb_adr_i = 32'd0;
    logic [31:0] wb_dat_i = 32'd0;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i = 4'hF;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic        wb_ack_o;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_ss_n = 1'b1;
    logic        spi_miso;
    logic        intr;

    int passed = 0;
    int total = 0;

    localparam logic [31:0] RXDATA = 32'h8000_0000;
    localparam logic [31:0] TXDATA = 32'h8000_0004;
    localparam logic [31:0] STATUS = 32'h8000_0008;
    localparam logic [31:0] CTRL   = 32'h8000_000C;

    wb_spi_slave dut (
        .clk(clk), .reset(reset),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n), .spi_miso(spi_miso),
        .intr(intr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        assert (got === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wb_adr_i = a; wb_dat_i = d; wb_we_i = 1'b1; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("wr_ack", {31'd0, wb_ack_o}, 32'd1);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        wb_adr_i = a; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rd_ack", {31'd0, wb_ack_o}, 32'd1);
        d = wb_dat_o;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic ss_low();
        @(negedge clk);
        spi_ss_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (4) @(negedge clk);
        spi_ss_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Shift nbits MSB-first; with sync_rd the RXDATA read lands on the final bit's completion edge.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, input bit sync_rd,
                            output logic [7:0] rx, output logic [31:0] rd_val);
        rx = 8'd0;
        rd_val = 32'd0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = tx[i];
            repeat (4) @(negedge clk);
            rx[i] = spi_miso;
            spi_sck = 1'b1;
            if (sync_rd && i == 0) begin
                @(negedge clk);
                wb_read(RXDATA, rd_val);
                @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            spi_sck = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] tx, input logic [7:0] exp_miso, input string tag);
        logic [7:0]  rx;
        logic [31:0] rv;
        ss_low();
        spi_xfer(tx, 8, 1'b0, rx, rv);
        ss_high();
        check(tag, {24'd0, rx}, {24'd0, exp_miso});
    endtask

    initial begin
        logic [7:0]  rx;
        logic [31:0] rv;

        repeat (3) @(negedge clk);
        check("reset_ack", {31'd0, wb_ack_o}, 32'd0);
        check("reset_dat", wb_dat_o, 32'd0);
        check("reset_miso", {31'd0, spi_miso}, 32'd1);
        check("reset_intr", {31'd0, intr}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        read_check("reset_status", STATUS, 32'h2);
        read_check("reset_ctrl", CTRL, 32'h0);
        read_check("reset_rxdata", RXDATA, 32'h0);
        check("idle_miso", {31'd0, spi_miso}, 32'd1);
        check("idle_intr", {31'd0, intr}, 32'd0);

        // Single byte exchange
        wb_write(TXDATA, 32'hA5);
        read_check("txdata_rb", TXDATA, 32'hA5);
        read_check("status_txfull", STATUS, 32'h0);
        frame(8'h3C, 8'hA5, "single_miso");
        read_check("single_status", STATUS, 32'h3);
        read_check("single_rxdata", RXDATA, 32'h3C);
        read_check("single_status2", STATUS, 32'h2);

        // Back-to-back bytes with TX empty, no read in between
        ss_low();
        read_check("busy_status", STATUS, 32'hA);
        spi_xfer(8'h11, 8, 1'b0, rx, rv);
        check("b2b_miso0", {24'd0, rx}, 32'hFF);
        spi_xfer(8'h22, 8, 1'b0, rx, rv);
        check("b2b_miso1", {24'd0, rx}, 32'hFF);
        ss_high();
        read_check("b2b_status", STATUS, 32'h7);
        wb_write(STATUS, 32'h4);
        read_check("ovr_clr_status", STATUS, 32'h3);
        read_check("b2b_rxdata", RXDATA, 32'h11);
        read_check("b2b_status2", STATUS, 32'h2);

        // Partial frame discarded, next full frame aligns from bit 7
        ss_low();
        spi_xfer(8'hA8, 5, 1'b0, rx, rv);
        ss_high();
        read_check("partial_status", STATUS, 32'h2);
        frame(8'h81, 8'hFF, "after_partial_miso");
        read_check("after_partial_rx", RXDATA, 32'h81);

        // Interrupts
        wb_write(CTRL, 32'h1);
        read_check("ctrl_rb", CTRL, 32'h1);
        check("intr_none", {31'd0, intr}, 32'd0);
        frame(8'h42, 8'hFF, "intr_frame_miso");
        repeat (2) @(negedge clk);
        check("intr_rx", {31'd0, intr}, 32'd1);
        read_check("intr_rxdata", RXDATA, 32'h42);
        repeat (2) @(negedge clk);
        check("intr_rx_clr", {31'd0, intr}, 32'd0);
        wb_write(CTRL, 32'h2);
        repeat (2) @(negedge clk);
        check("intr_tx_empty", {31'd0, intr}, 32'd1);
        wb_write(TXDATA, 32'h5C);
        repeat (2) @(negedge clk);
        check("intr_tx_full", {31'd0, intr}, 32'd0);
        wb_write(CTRL, 32'h0);

        // Read of RXDATA coinciding with byte completion
        frame(8'h5A, 8'h5C, "sim_pre_miso");
        read_check("sim_pre_status", STATUS, 32'h3);
        ss_low();
        spi_xfer(8'hC3, 8, 1'b1, rx, rv);
        ss_high();
        check("sim_miso", {24'd0, rx}, 32'hFF);
        check("sim_old_byte", rv, 32'h5A);
        read_check("sim_status", STATUS, 32'h3);
        read_check("sim_new_byte", RXDATA, 32'hC3);
        read_check("sim_status2", STATUS, 32'h2);

        // Reset mid-frame: shifting must not resume until a fresh ss_n fall
        ss_low();
        spi_xfer(8'hE0, 3, 1'b0, rx, rv);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        spi_xfer(8'h99, 8, 1'b0, rx, rv);
        check("rstmid_miso", {24'd0, rx}, 32'hFF);
        read_check("rstmid_status", STATUS, 32'hA);
        ss_high();
        read_check("rstmid_status2", STATUS, 32'h2);
        frame(8'h66, 8'hFF, "rstmid_after_miso");
        read_check("rstmid_after_rx", RXDATA, 32'h66);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
